minimal_dma_control_regs: RTL

AXI4-Lite slave (responder) exposing the control/status register file of the minimal DMA controller; it is the far end of the AXI4-Lite master BFM transactions used in the block-design bench. It accepts single-beat writes and reads to four 32-bit registers and converts them into DMA-side control signals. It also folds DMA completion and error events back into a readable, write-1-to-clear status word.

---
 rtl/minimal_dma_control_pkg.sv | 51 +++++
 rtl/minimal_dma_control_wr_join.sv | 124 ++++++++++++
 rtl/minimal_dma_control_regs.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/minimal_dma_control_pkg.sv
// Shared definitions for the minimal DMA control/status register block:
// register offsets, bit positions, AXI response code and FSM encodings.
package minimal_dma_control_pkg;

  // Byte offsets of the four 32-bit registers
  localparam logic [3:0] OFFSET_CTRL   = 4'h0;
  localparam logic [3:0] OFFSET_ADDR   = 4'h4;
  localparam logic [3:0] OFFSET_LEN    = 4'h8;
  localparam logic [3:0] OFFSET_STATUS = 4'hC;

  // Word indices (address bits [3:2]) derived from the byte offsets
  localparam logic [1:0] IDX_CTRL   = OFFSET_CTRL[3:2];
  localparam logic [1:0] IDX_ADDR   = OFFSET_ADDR[3:2];
  localparam logic [1:0] IDX_LEN    = OFFSET_LEN[3:2];
  localparam logic [1:0] IDX_STATUS = OFFSET_STATUS[3:2];

  // CTRL bit positions
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  // STATUS bit positions
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_ERR_BIT  = 2;

  // The only response this slave ever returns
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

  // Merge new_val into old_val one byte lane at a time under strb
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/minimal_dma_control_wr_join.sv
// Write-side AXI4-Lite front end: captures AW and W beats independently,
// joins them into a single write_fire strobe and runs the B response FSM.
module minimal_dma_control_wr_join
  import minimal_dma_control_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  write_fire,
  output logic [ADDR_W-1:0]     write_addr,
  output logic [DATA_W-1:0]     write_data,
  output logic [DATA_W/8-1:0]   write_strb
);

  wr_state_e             wr_state_q, wr_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic                  aw_hs, w_hs;

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = RESP_OKAY;

  // Join: a beat counts as present if it is held or handshaking right now,
  // so the second beat to arrive fires the write on its own handshake edge
  always_comb begin
    aw_hs      = awvalid && awready_q;
    w_hs       = wvalid && wready_q;
    write_fire = (wr_state_q == WR_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    write_addr = aw_held_q ? awaddr_q : awaddr;
    write_data = w_held_q ? wdata_q : wdata;
    write_strb = w_held_q ? wstrb_q : wstrb;
  end

  // Next-state logic: capture beats in idle, respond, then reopen both channels
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
          awready_d = 1'b0;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
          wready_d = 1'b0;
        end
        if (write_fire) begin
          wr_state_d = WR_RESP;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          bvalid_d   = 1'b1;
        end
      end
      WR_RESP: begin
        if (bready) begin
          wr_state_d = WR_IDLE;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          bvalid_d   = 1'b0;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // State and registered handshake outputs; reset drops any in-flight beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
    end
  end

endmodule

// File: rtl/minimal_dma_control_regs.sv
// AXI4-Lite control/status register file for the minimal DMA controller.
// Holds CTRL/ADDR/LEN/STATUS, issues dma_start pulses and folds DMA
// completion and start-while-busy errors into a sticky W1C status word.
module minimal_dma_control_regs
  import minimal_dma_control_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            dma_start,
  output logic [31:0]                     dma_addr,
  output logic [31:0]                     dma_len,
  input  logic                            dma_busy,
  input  logic                            dma_done
);

  logic                            write_fire;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;

  logic        irq_en_q, irq_en_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] len_q, len_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        dma_start_q, dma_start_d;
  logic        done_clr, err_clr, err_set;

  rd_state_e   rd_state_q, rd_state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] read_word;

  logic        unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], wr_addr[1:0]};

  minimal_dma_control_wr_join #(
    .ADDR_W (C_S_AXI_ADDR_WIDTH),
    .DATA_W (C_S_AXI_DATA_WIDTH)
  ) u_wr_join (
    .clk        (S_AXI_ACLK),
    .rst        (S_AXI_ARESET),
    .awaddr     (S_AXI_AWADDR),
    .awvalid    (S_AXI_AWVALID),
    .awready    (S_AXI_AWREADY),
    .wdata      (S_AXI_WDATA),
    .wstrb      (S_AXI_WSTRB),
    .wvalid     (S_AXI_WVALID),
    .wready     (S_AXI_WREADY),
    .bresp      (S_AXI_BRESP),
    .bvalid     (S_AXI_BVALID),
    .bready     (S_AXI_BREADY),
    .write_fire (write_fire),
    .write_addr (wr_addr),
    .write_data (wr_data),
    .write_strb (wr_strb)
  );

  assign dma_start     = dma_start_q;
  assign dma_addr      = addr_q;
  assign dma_len       = len_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

  // Register updates on write_fire; dma_done set takes priority over a W1C clear
  always_comb begin
    irq_en_d    = irq_en_q;
    addr_d      = addr_q;
    len_d       = len_q;
    dma_start_d = 1'b0;
    done_clr    = 1'b0;
    err_clr     = 1'b0;
    err_set     = 1'b0;
    if (write_fire) begin
      case (wr_addr[3:2])
        IDX_CTRL: begin
          if (wr_strb[0]) begin
            irq_en_d = wr_data[CTRL_IRQ_EN_BIT];
            if (wr_data[CTRL_START_BIT]) begin
              if (dma_busy) err_set = 1'b1;
              else          dma_start_d = 1'b1;
            end
          end
        end
        IDX_ADDR: addr_d = apply_wstrb(addr_q, wr_data, wr_strb);
        IDX_LEN:  len_d  = apply_wstrb(len_q, wr_data, wr_strb);
        IDX_STATUS: begin
          if (wr_strb[0]) begin
            done_clr = wr_data[STATUS_DONE_BIT];
            err_clr  = wr_data[STATUS_ERR_BIT];
          end
        end
        default: ;
      endcase
    end
    done_d = (done_q && !done_clr) || dma_done;
    err_d  = (err_q && !err_clr) || err_set;
  end

  // Read mux from the current (pre-write) register values and live busy
  always_comb begin
    read_word = '0;
    case (S_AXI_ARADDR[3:2])
      IDX_CTRL:   read_word[CTRL_IRQ_EN_BIT] = irq_en_q;
      IDX_ADDR:   read_word = addr_q;
      IDX_LEN:    read_word = len_q;
      IDX_STATUS: begin
        read_word[STATUS_BUSY_BIT] = dma_busy;
        read_word[STATUS_DONE_BIT] = done_q;
        read_word[STATUS_ERR_BIT]  = err_q;
      end
      default: read_word = '0;
    endcase
  end

  // Read FSM: accept one AR, present latched data until RREADY
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          rd_state_d = RD_DATA;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = read_word;
        end
      end
      RD_DATA: begin
        if (S_AXI_RREADY) begin
          rd_state_d = RD_IDLE;
          arready_d  = 1'b1;
          rvalid_d   = 1'b0;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Register file, start pulse and read channel state
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      irq_en_q    <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dma_start_q <= 1'b0;
      rd_state_q  <= RD_IDLE;
      arready_q   <= 1'b1;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      irq_en_q    <= irq_en_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      done_q      <= done_d;
      err_q       <= err_d;
      dma_start_q <= dma_start_d;
      rd_state_q  <= rd_state_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule
